// File: rtl/dpsk_mod_if.sv
// Bit-input handshake and modulator output bundle for the 2DPSK transmitter.
// The master drives data bits in; the slave (modulator) returns the carrier
// samples and symbol status.
interface dpsk_mod_if;
   logic       bit_in;
   logic       bit_valid;
   logic       bit_ready;
   logic [7:0] mod_out;
   logic       sym_start;
   logic       busy;
   logic       diff_bit;

   modport master (
      output bit_in, bit_valid,
      input  bit_ready, mod_out, sym_start, busy, diff_bit
   );

   modport slave (
      input  bit_in, bit_valid,
      output bit_ready, mod_out, sym_start, busy, diff_bit
   );
endinterface

// File: rtl/dpsk_mod.sv
// 2DPSK modulator: differentially encodes accepted bits (d = b ^ d_prev) and
// emits an 8-bit offset-binary sine carrier, one sample per clk. The carrier
// is inverted for the whole symbol when d = 1. A single holding register
// decouples the bit handshake from symbol timing, so that symbols run
// back-to-back whenever the next bit arrives before the current symbol ends.
module dpsk_mod #(
   parameter int SYM_CYCLES = 128,
   parameter int DATA_W     = 8
) (
   input logic       clk,
   input logic       reset,
   dpsk_mod_if.slave bus
);

   localparam int                CNT_W    = $clog2(SYM_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SYM_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [0:0]        ST_IDLE  = 1'b0;
   localparam logic [0:0]        ST_SEND  = 1'b1;
   localparam logic [DATA_W-1:0] MID_LVL  = 8'h80;

   // One period of the carrier: 128 + round(127*sin(2*pi*i/32)).
   function automatic logic [7:0] sine_lut(input logic [4:0] idx);
      logic [7:0] val;
      case (idx)
         5'd0:  val = 8'h80;  5'd1:  val = 8'h99;  5'd2:  val = 8'hB1;  5'd3:  val = 8'hC7;
         5'd4:  val = 8'hDA;  5'd5:  val = 8'hEA;  5'd6:  val = 8'hF5;  5'd7:  val = 8'hFD;
         5'd8:  val = 8'hFF;  5'd9:  val = 8'hFD;  5'd10: val = 8'hF5;  5'd11: val = 8'hEA;
         5'd12: val = 8'hDA;  5'd13: val = 8'hC7;  5'd14: val = 8'hB1;  5'd15: val = 8'h99;
         5'd16: val = 8'h80;  5'd17: val = 8'h67;  5'd18: val = 8'h4F;  5'd19: val = 8'h39;
         5'd20: val = 8'h26;  5'd21: val = 8'h16;  5'd22: val = 8'h0B;  5'd23: val = 8'h03;
         5'd24: val = 8'h01;  5'd25: val = 8'h03;  5'd26: val = 8'h0B;  5'd27: val = 8'h16;
         5'd28: val = 8'h26;  5'd29: val = 8'h39;  5'd30: val = 8'h4F;  5'd31: val = 8'h67;
         default: val = 8'h80;
      endcase
      return val;
   endfunction

   logic [0:0]        state_r,     state_nxt_s;
   logic [CNT_W-1:0]  cnt_r,       cnt_nxt_s;
   logic              d_r,         d_nxt_s;
   logic              hold_r,      hold_nxt_s;
   logic              hold_full_r, hold_full_nxt_s;
   logic [DATA_W-1:0] mod_out_r,   mod_out_nxt_s;
   logic              sym_start_r, sym_start_nxt_s;
   logic              busy_r,      busy_nxt_s;
   logic              load_s;
   logic              d_load_s;

   // Next-state logic: symbol sequencing, hold-register load and bit acceptance.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      d_nxt_s         = d_r;
      hold_nxt_s      = hold_r;
      hold_full_nxt_s = hold_full_r;
      mod_out_nxt_s   = mod_out_r;
      sym_start_nxt_s = 1'b0;
      busy_nxt_s      = busy_r;
      load_s          = 1'b0;
      d_load_s        = d_r ^ hold_r;

      case (state_r)
         ST_IDLE: begin
            mod_out_nxt_s = MID_LVL;
            busy_nxt_s    = 1'b0;
            cnt_nxt_s     = '0;
            if (hold_full_r) begin
               load_s = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         ST_SEND: begin
            if (cnt_r == CNT_LAST) begin
               if (hold_full_r) begin
                  load_s = 1'b1;
               end else begin
                  state_nxt_s   = ST_IDLE;
                  mod_out_nxt_s = MID_LVL;
                  busy_nxt_s    = 1'b0;
                  cnt_nxt_s     = '0;
               end
            end else begin
               cnt_nxt_s     = cnt_r + CNT_ONE;
               mod_out_nxt_s = sine_lut(cnt_nxt_s[4:0]) ^ {8{d_r}};
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            mod_out_nxt_s = MID_LVL;
            busy_nxt_s    = 1'b0;
            cnt_nxt_s     = '0;
         end
      endcase

      // A load needs hold_full=1 and an accept needs hold_full=0, so the two
      // can never coincide; the load branch wins structurally anyway.
      if (load_s) begin
         state_nxt_s     = ST_SEND;
         d_nxt_s         = d_load_s;
         hold_full_nxt_s = 1'b0;
         cnt_nxt_s       = '0;
         mod_out_nxt_s   = sine_lut(5'd0) ^ {8{d_load_s}};
         sym_start_nxt_s = 1'b1;
         busy_nxt_s      = 1'b1;
      end else if (bus.bit_valid && !hold_full_r) begin
         hold_nxt_s      = bus.bit_in;
         hold_full_nxt_s = 1'b1;
      end else begin
         hold_full_nxt_s = hold_full_nxt_s;
      end
   end

   // State and output registers; reset discards any partial symbol and held bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         d_r         <= 1'b0;
         hold_r      <= 1'b0;
         hold_full_r <= 1'b0;
         mod_out_r   <= MID_LVL;
         sym_start_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         d_r         <= d_nxt_s;
         hold_r      <= hold_nxt_s;
         hold_full_r <= hold_full_nxt_s;
         mod_out_r   <= mod_out_nxt_s;
         sym_start_r <= sym_start_nxt_s;
         busy_r      <= busy_nxt_s;
      end
   end

   assign bus.bit_ready = ~hold_full_r;
   assign bus.mod_out   = mod_out_r;
   assign bus.sym_start = sym_start_r;
   assign bus.busy      = busy_r;
   assign bus.diff_bit  = d_r;

endmodule

// File: tb/tb_dpsk_mod.sv
// Directed testbench for dpsk_mod: reset behaviour, single and back-to-back
// symbols, handshake back-pressure, idle gaps and MSB-slicing recovery.
module tb_dpsk_mod;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   logic rx_prev  = 1'b0;
   logic [7:0] lut [0:31];

   dpsk_mod_if bus ();

   dpsk_mod #(.SYM_CYCLES(128), .DATA_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input logic d_exp);
      chk("idle_mod_out", 32'(bus.mod_out), 32'h80);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_sym_start", 32'(bus.sym_start), 32'd0);
      chk("idle_ready", 32'(bus.bit_ready), 32'd1);
      chk("idle_diff_bit", 32'(bus.diff_bit), 32'(d_exp));
   endtask

   // Called just after a load edge; walks the 128 samples of the symbol and
   // ends sitting on the last sample. The bit on the inputs at sample 0 is
   // accepted on the following edge if bit_valid is high; the inputs are then
   // switched to nb_valid/nb_bit.
   task automatic check_symbol(input logic sent, input logic d_exp,
                               input logic nb_valid, input logic nb_bit);
      logic       accepted;
      logic       msb32;
      logic       rx_d;
      logic [7:0] exp_s;
      accepted = 1'b0;
      msb32    = 1'b0;
      chk("sym_start_first", 32'(bus.sym_start), 32'd1);
      chk("sym_busy", 32'(bus.busy), 32'd1);
      chk("sym_diff_bit", 32'(bus.diff_bit), 32'(d_exp));
      chk("sym_ready_at_load", 32'(bus.bit_ready), 32'd1);
      exp_s = lut[0] ^ {8{d_exp}};
      chk("sample_0", 32'(bus.mod_out), 32'(exp_s));
      for (int i = 1; i < 128; i++) begin
         if (i == 1) accepted = bus.bit_valid;
         tick();
         exp_s = lut[i % 32] ^ {8{d_exp}};
         chk($sformatf("sample_%0d", i), 32'(bus.mod_out), 32'(exp_s));
         chk("sym_start_mid", 32'(bus.sym_start), 32'd0);
         chk("ready_until_load", 32'(bus.bit_ready), 32'(!accepted));
         if (i == 1) begin
            bus.bit_valid = nb_valid;
            bus.bit_in    = nb_bit;
         end
         if (i == 32) msb32 = bus.mod_out[7];
      end
      chk("sym_busy_end", 32'(bus.busy), 32'd1);
      rx_d = ~msb32;
      chk("rx_bit", 32'(rx_d ^ rx_prev), 32'(sent));
      rx_prev = rx_d;
   endtask

   initial begin
      lut[0]  = 8'h80; lut[1]  = 8'h99; lut[2]  = 8'hB1; lut[3]  = 8'hC7;
      lut[4]  = 8'hDA; lut[5]  = 8'hEA; lut[6]  = 8'hF5; lut[7]  = 8'hFD;
      lut[8]  = 8'hFF; lut[9]  = 8'hFD; lut[10] = 8'hF5; lut[11] = 8'hEA;
      lut[12] = 8'hDA; lut[13] = 8'hC7; lut[14] = 8'hB1; lut[15] = 8'h99;
      lut[16] = 8'h80; lut[17] = 8'h67; lut[18] = 8'h4F; lut[19] = 8'h39;
      lut[20] = 8'h26; lut[21] = 8'h16; lut[22] = 8'h0B; lut[23] = 8'h03;
      lut[24] = 8'h01; lut[25] = 8'h03; lut[26] = 8'h0B; lut[27] = 8'h16;
      lut[28] = 8'h26; lut[29] = 8'h39; lut[30] = 8'h4F; lut[31] = 8'h67;
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;

      // Reset state
      #2 reset = 1'b1;
      tick();
      tick();
      check_idle(1'b0);
      reset = 1'b0;
      tick();
      check_idle(1'b0);

      // Single bit 0: accept, load one edge later, 128 normal samples, idle
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b0;
      tick();
      chk("accept_ready_low", 32'(bus.bit_ready), 32'd0);
      chk("accept_no_start", 32'(bus.sym_start), 32'd0);
      chk("accept_still_idle", 32'(bus.mod_out), 32'h80);
      bus.bit_valid = 1'b0;
      tick();
      check_symbol(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_idle(1'b0);

      // Bits 1,1,0,1 back-to-back with bit_valid held high: d = 1,0,0,1
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      tick();
      chk("b2b_ready_low", 32'(bus.bit_ready), 32'd0);
      bus.bit_in = 1'b1;
      tick();
      chk("b2b_first_7f", 32'(bus.mod_out), 32'h7F);
      check_symbol(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      chk("b2b_second_80", 32'(bus.mod_out), 32'h80);
      check_symbol(1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      chk("b2b_third_80", 32'(bus.mod_out), 32'h80);
      check_symbol(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("b2b_fourth_7f", 32'(bus.mod_out), 32'h7F);
      check_symbol(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check_idle(1'b1);

      // Reset mid-symbol at cnt=50 (d stays 1 for a 0 bit)
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b0;
      tick();
      bus.bit_valid = 1'b0;
      tick();
      chk("pre_rst_start", 32'(bus.sym_start), 32'd1);
      for (int i = 0; i < 50; i++) tick();
      chk("pre_rst_sample50", 32'(bus.mod_out), 32'hB0);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mod_out", 32'(bus.mod_out), 32'h80);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ready", 32'(bus.bit_ready), 32'd1);
      chk("rst_diff_bit", 32'(bus.diff_bit), 32'd0);
      chk("rst_sym_start", 32'(bus.sym_start), 32'd0);
      tick();
      reset   = 1'b0;
      rx_prev = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_idle(1'b0);
      end

      // Bit 1, a 300-cycle idle gap, then bit 1: d goes 1 then 0
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      tick();
      bus.bit_valid = 1'b0;
      tick();
      check_symbol(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check_idle(1'b1);
      for (int i = 1; i < 300; i++) begin
         tick();
         check_idle(1'b1);
      end
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      tick();
      chk("gap_accept_ready", 32'(bus.bit_ready), 32'd0);
      chk("gap_accept_mod", 32'(bus.mod_out), 32'h80);
      bus.bit_valid = 1'b0;
      tick();
      check_symbol(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_idle(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
